scale_cache_filler: RTL
=======================

Name: scale_cache_filler

Overview:
- Fills the scale cache with one downscaled frame.
- Accepts a raster-order source pixel stream over a valid/ready handshake and decimates it by nearest neighbour with a fixed-point step.
- Drives the scale cache write interface (waddrY, waddrX, wdata, we); it is the writer end of that interface.
- Sits between the frame-source stage and the scale cache; the detector reads the cache after done.

Parameters:
- WORD_SIZE, 8, pixel width in bits; equals the scale cache word width.
- SRC_W, 320, source pixels per row.
- SRC_H, 240, source rows per frame.
- DST_W, 64, scale cache row size (columns).
- DST_H, 64, scale cache rows.
- FRAC_BITS, 8, fractional bits of step.
- ACC_W, 24, width of the nx/ny sample-point accumulators.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that begins a frame; sampled only in IDLE.
- step, in, 16, source pixels per destination pixel, unsigned Q8.FRAC_BITS.
- in_valid, in, 1, source pixel valid.
- in_data, in, WORD_SIZE, source pixel.
- in_ready, out, 1, block accepts a pixel this cycle.
- scw_waddrY, out, clog2(DST_H), cache row address.
- scw_waddrX, out, clog2(DST_W), cache column address.
- scw_wdata, out, WORD_SIZE, cache write data.
- scw_we, out, 1, cache write enable.
- busy, out, 1, high in FILL.
- done, out, 1, one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and accumulators 0. Reset mid-frame abandons the frame with no done pulse, and scw_we is 0 from the next edge. Cache contents are not cleared.
- States: IDLE, FILL, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch step_r = max(step, 1<<FRAC_BITS), so steps below 1.0 clamp to 1.0.
  - Clear sx, sy, dx, dy, nx, ny. Go to FILL.
- FILL:
  - busy=1, in_ready=1.
  - Accept occurs when in_valid && in_ready; no other event advances the counters. in_valid gaps stall with no side effects.
  - Pixel at (sx,sy) is written when all of: sy==ny[ACC_W-1:FRAC_BITS], dy<DST_H, sx==nx[ACC_W-1:FRAC_BITS], dx<DST_W.
  - Write is registered: scw_we=1 the cycle after accept, with scw_waddrY=dy, scw_waddrX=dx and scw_wdata=in_data as captured at accept.
  - scw_we=0 on every cycle without a write. Addresses and data hold their last value when scw_we=0.
  - Column selected: nx += step_r, dx += 1.
  - Row end (sx==SRC_W-1): sx=0, nx=0, dx=0, sy += 1. If the row was selected (sy matched and dy<DST_H): ny += step_r, dy += 1.
  - Last pixel (sx==SRC_W-1, sy==SRC_H-1): go to DONE. in_ready=0 from the next cycle, and the final write, if any, still issues that cycle.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Sample points: because step_r >= 1.0, the integer part of nx/ny increases by at least 1 per selection, so no sample is skipped.
- Arithmetic widths: accumulators are ACC_W bits and unsigned. Once dx reaches DST_W (or dy reaches DST_H) the accumulator stops advancing, so it cannot overflow.
- Unused cache area: columns at or beyond DST_W and rows at or beyond DST_H are never written. A small frame with a large step leaves unused cache rows untouched.
- start while in FILL or DONE is ignored. step changes after start have no effect.

Optional Feature:
- Macro: SCALE_CACHE_FILLER_WRCOUNT_EN.
- With the macro defined:
  - Adds output wr_count, width clog2(DST_W*DST_H+1).
  - Cleared on start and on rst; increments on every scw_we cycle.
  - Holds its value after done until the next start.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Test Plan:
- step=0x0100, defaults, continuous in_valid, in_data=sx[7:0] -> exactly 4096 writes. Addresses run (0,0)..(63,63) in raster order, wdata=waddrX, source rows 64..239 produce no writes, one done pulse follows the last accepted pixel.
- step=0x0500 -> columns sampled at sx 0,5,..,315 (64 per row), 48 rows selected (dy 0..47), 3072 writes. The write at (dy=47, dx=63) carries the pixel from (sy=235, sx=315).
- step=0x0280 -> first-row writes at sx 0,2,5,7,10 map to dx 0..4; the second selected row is sy=2, then sy=5.
- step=0x0080 -> behaves exactly as step=0x0100.
- Backpressure: in_valid toggled randomly (50%) -> write sequence identical to the continuous case. Each scw_we follows its accept by exactly 1 cycle.
- Control: rst asserted at pixel 1000 -> next cycle scw_we=0, busy=0, no done pulse; a new start restarts the frame at (0,0). Separately, start pulsed during FILL -> ignored, write count unchanged. With the macro defined, wr_count=4096 after frame 1.

Source files
------------

// File: rtl/scale_cache_filler.sv
// scale_cache_filler
//   Fills the scale cache with one nearest-neighbour downscaled frame.
//   A raster-order source stream arrives over valid/ready; pixels whose
//   coordinates land on the fixed-point sample grid (pitch = step) are
//   written to the cache one cycle after they are accepted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle frame start, sampled only in IDLE
//   step              source pixels per destination pixel, unsigned Q8.FRAC_BITS
//   in_valid/in_data  source pixel stream
//   in_ready          pixel accepted this cycle when in_valid is also high
//   scw_waddrY/X      cache row/column address
//   scw_wdata/scw_we  cache write data / enable
//   busy              frame in progress
//   done              one-cycle pulse at end of frame
//   wr_count          writes in the current/last frame
//                     (only with SCALE_CACHE_FILLER_WRCOUNT_EN defined)
//
// States
//   IDLE | waiting for start; step latched and counters cleared on start
//   FILL | accepting source pixels and writing sampled ones
//   DONE | one-cycle done pulse; final write may still be on the bus
module scale_cache_filler #(
  parameter int WORD_SIZE = 8,
  parameter int SRC_W     = 320,
  parameter int SRC_H     = 240,
  parameter int DST_W     = 64,
  parameter int DST_H     = 64,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  step,
  input  logic                         in_valid,
  input  logic [WORD_SIZE-1:0]         in_data,
  output logic                         in_ready,
  output logic [$clog2(DST_H)-1:0]     scw_waddrY,
  output logic [$clog2(DST_W)-1:0]     scw_waddrX,
  output logic [WORD_SIZE-1:0]         scw_wdata,
  output logic                         scw_we,
  output logic                         busy,
  output logic                         done
`ifdef SCALE_CACHE_FILLER_WRCOUNT_EN
  ,
  output logic [$clog2(DST_W*DST_H+1)-1:0] wr_count
`endif
);

  localparam int SXW = $clog2(SRC_W);
  localparam int SYW = $clog2(SRC_H);
  localparam int DXW = $clog2(DST_W + 1);
  localparam int DYW = $clog2(DST_H + 1);
  localparam int AXW = $clog2(DST_W);
  localparam int AYW = $clog2(DST_H);
  localparam int IW  = ACC_W - FRAC_BITS;

  localparam logic [SXW-1:0] SX_LAST = SXW'(SRC_W - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SRC_H - 1);
  localparam logic [DXW-1:0] DX_LIM  = DXW'(DST_W);
  localparam logic [DYW-1:0] DY_LIM  = DYW'(DST_H);
  localparam logic [15:0]    STEP_ONE = 16'(1 << FRAC_BITS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t state_q, state_d;

  logic [15:0]    step_r;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic [ACC_W-1:0] nx, ny;

  logic accept, row_hit, col_hit, row_end, last_px, frame_start;

  // Sample-point matching uses only the integer part of the accumulators.
  assign row_hit = (IW'(sy) == ny[ACC_W-1:FRAC_BITS]) && (dy < DY_LIM);
  assign col_hit = row_hit && (IW'(sx) == nx[ACC_W-1:FRAC_BITS]) && (dx < DX_LIM);
  assign row_end = (sx == SX_LAST);
  assign last_px = row_end && (sy == SY_LAST);

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (in_valid && last_px) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_r     <= '0;
      sx         <= '0;
      sy         <= '0;
      dx         <= '0;
      dy         <= '0;
      nx         <= '0;
      ny         <= '0;
      scw_we     <= 1'b0;
      scw_waddrY <= '0;
      scw_waddrX <= '0;
      scw_wdata  <= '0;
    end else begin
      scw_we <= accept && col_hit;
      if (accept && col_hit) begin
        scw_waddrY <= dy[AYW-1:0];
        scw_waddrX <= dx[AXW-1:0];
        scw_wdata  <= in_data;
      end

      if (frame_start) begin
        // Steps below 1.0 would revisit source pixels; clamp to 1.0.
        step_r <= (step < STEP_ONE) ? STEP_ONE : step;
        sx     <= '0;
        sy     <= '0;
        dx     <= '0;
        dy     <= '0;
        nx     <= '0;
        ny     <= '0;
      end else if (accept) begin
        if (col_hit) begin
          nx <= nx + ACC_W'(step_r);
          dx <= dx + DXW'(1);
        end
        if (row_end) begin
          sx <= '0;
          nx <= '0;
          dx <= '0;
          sy <= sy + SYW'(1);
          if (row_hit) begin
            ny <= ny + ACC_W'(step_r);
            dy <= dy + DYW'(1);
          end
        end else begin
          sx <= sx + SXW'(1);
        end
      end
    end
  end

`ifdef SCALE_CACHE_FILLER_WRCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst || frame_start) wr_count <= '0;
    else if (scw_we)        wr_count <= wr_count + 1'b1;
  end
`endif

endmodule
